add_operand_ctrl: RTL and testbench
===================================

ADD_OPERAND_CTRL -- requirements
Module: add_operand_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, is the operand/result width; the bench exercises only 32.
REQ-002 Parameter SETTLE_CYC, default 4, is the number of cycles the adder inputs are held before the sum is sampled; legal range 1..15.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operand request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_a, in_b  input  WIDTH  operands.
REQ-009 in_op  input  1  0 = add, 1 = subtract (a - b).
REQ-010 add_a, add_b  output  WIDTH  registered operands driven to the 32-bit carry-select adder.
REQ-011 add_cin  output  1  registered carry-in driven to the adder.
REQ-012 add_s  input  WIDTH  adder sum; add_cout  input  1  adder carry-out.
REQ-013 out_valid  output  1  result available; out_ready  input  1  consumer accepts the result.
REQ-014 out_res  output  WIDTH  result; out_c, out_v, out_z  output  1 each  carry, signed overflow, zero flags.

Function
REQ-015 FSM states IDLE, DRIVE, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE: on in_valid && in_ready, latch add_a = in_a, add_b = in_op ? ~in_b : in_b, add_cin = in_op, load settle counter with SETTLE_CYC-1, go to DRIVE.
REQ-017 DRIVE: add_a, add_b, add_cin stay constant; counter decrements each edge while nonzero; on the edge where counter is 0, capture add_s/add_cout into result/flags and go to DONE.
REQ-018 Latency: out_valid rises exactly SETTLE_CYC rising edges after the accepting edge (4 with default).
REQ-019 DONE: out_res and flags hold stable until out_valid && out_ready; on that edge go to IDLE; in_valid is ignored in DRIVE and DONE.
REQ-020 out_c = add_cout as captured (for subtract, 1 means no borrow).
REQ-021 out_v = 1 when add_a[MSB] == add_b[MSB] and add_s[MSB] != add_a[MSB].
REQ-022 out_z = 1 when the final out_res equals 0.
REQ-023 add_a, add_b, add_cin retain their last values in IDLE and DONE; they change only on an accepting edge.
REQ-024 Back-to-back: minimum request spacing is SETTLE_CYC+2 cycles (accept, settle, done with out_ready=1, idle).
REQ-025 out_ready held low keeps DONE indefinitely with no output change.

Reset
REQ-026 On a rising edge with rst_n = 0: state = IDLE, counter = 0, add_a = add_b = 0, add_cin = 0, out_res = 0, out_c = out_v = out_z = 0, out_valid = 0; in_ready = 1 on the first cycle after rst_n returns high.
REQ-027 Reset during DRIVE or DONE abandons the operation; no result is ever presented for it.

Configuration
REQ-028 Macro ADD_SAT_EN: when defined, an overflowing result (out_v = 1) is replaced by 0x7FFF_FFFF if add_a[MSB] = 0 or 0x8000_0000 if add_a[MSB] = 1; out_v still reports 1 and out_c is the raw carry.
REQ-029 Without ADD_SAT_EN, out_res is always the raw captured add_s.

Verification
REQ-030 Add 0x0000_0005 + 0x0000_0003, op=0 -> add_b=0x3, add_cin=0; out_valid 4 edges after accept; out_res=0x8, c=0, v=0, z=0.
REQ-031 Subtract 0x0000_0007 - 0x0000_0007 -> add_b=0xFFFF_FFF8, add_cin=1; out_res=0, c=1, v=0, z=1.
REQ-032 Add 0x7FFF_FFFF + 0x0000_0001 -> without ADD_SAT_EN out_res=0x8000_0000, v=1; with ADD_SAT_EN out_res=0x7FFF_FFFF, v=1.
REQ-033 Add 0xFFFF_FFFF + 0x0000_0001 -> out_res=0, c=1, v=0, z=1.
REQ-034 Hold out_ready=0 for 10 cycles in DONE while pulsing in_valid -> in_ready stays 0, result unchanged, second request not accepted until after handshake.
REQ-035 Assert rst_n=0 for one edge two cycles into DRIVE -> out_valid never rises, all outputs 0, in_ready=1 after release.

Source files
------------

// File: rtl/add_operand_ctrl_if.sv
// Request, adder-drive and result signals between add_operand_ctrl (slave) and its environment (master).
interface add_operand_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_op;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_c;
  logic             out_v;
  logic             out_z;

  modport master (
    output in_valid, in_a, in_b, in_op, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_res, out_c, out_v, out_z
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_res, out_c, out_v, out_z
  );
endinterface

// File: rtl/add_operand_ctrl.sv
// Holds operands on an external adder for SETTLE_CYC cycles, then captures sum and C/V/Z flags.
// Defining ADD_SAT_EN saturates signed-overflowing results; default build passes the raw sum.
module add_operand_ctrl #(
  parameter int WIDTH      = 32,
  parameter int SETTLE_CYC = 4
) (
  input logic               clk,
  input logic               rst_n,
  add_operand_ctrl_if.slave bus
);
  localparam int         MSB      = WIDTH - 1;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             accept, capture, ovf;
  logic [WIDTH-1:0] add_a, add_b, res, res_nxt;
  logic             add_cin, flag_c, flag_v, flag_z;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Overflow is judged on the operands actually presented, so subtract uses the inverted b.
  always_comb begin
    ovf     = (add_a[MSB] == add_b[MSB]) && (bus.add_s[MSB] != add_a[MSB]);
    res_nxt = bus.add_s;
`ifdef ADD_SAT_EN
    if (ovf) res_nxt = add_a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      res     <= '0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        add_a   <= bus.in_a;
        add_b   <= bus.in_op ? ~bus.in_b : bus.in_b;
        add_cin <= bus.in_op;
      end
      if (capture) begin
        res    <= res_nxt;
        flag_c <= bus.add_cout;
        flag_v <= ovf;
        flag_z <= (res_nxt == '0);
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;
  assign bus.add_cin   = add_cin;
  assign bus.out_res   = res;
  assign bus.out_c     = flag_c;
  assign bus.out_v     = flag_v;
  assign bus.out_z     = flag_z;
endmodule

// File: tb/tb_add_operand_ctrl.sv
// Bench for add_operand_ctrl: models the adder and checks results against an arithmetic reference.
module tb_add_operand_ctrl;
  localparam int SETTLE = 4;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errs   = 0;
  int   checks = 0;

  add_operand_ctrl_if #(.WIDTH(32)) bus ();

  add_operand_ctrl #(.WIDTH(32), .SETTLE_CYC(SETTLE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Ideal adder standing in for the carry-select block.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    res_t   r;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = op ? (sa - sb) : (sa + sb);
    r.res = s[31:0];
    r.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r.c   = op ? (a >= b) : (({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF);
`ifdef ADD_SAT_EN
    if (r.v) r.res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    r.z = (r.res == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.add_a !== 32'd0 || bus.add_b !== 32'd0 ||
        bus.add_cin !== 1'b0 || bus.out_res !== 32'd0 || {bus.out_c, bus.out_v, bus.out_z} !== 3'b000) begin
      errs++;
      $display("FAIL reset_state: rdy=%b vld=%b a=%h b=%h cin=%b res=%h cvz=%b%b%b required rdy=1 all else 0",
               bus.in_ready, bus.out_valid, bus.add_a, bus.add_b, bus.add_cin, bus.out_res,
               bus.out_c, bus.out_v, bus.out_z);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: rdy=%b vld=%b required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[4] = '{32'h5, 32'h7, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vb[4] = '{32'h3, 32'h7, 32'h1, 32'h1};
    logic        vo[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
`ifdef ADD_SAT_EN
    logic [31:0] er[4] = '{32'h8, 32'h0, 32'h7FFF_FFFF, 32'h0};
`else
    logic [31:0] er[4] = '{32'h8, 32'h0, 32'h8000_0000, 32'h0};
`endif
    logic [2:0]  ef[4] = '{3'b000, 3'b101, 3'b010, 3'b101};
    logic [31:0] eb;
    for (int i = 0; i < 4; i++) begin
      bus.in_a = va[i]; bus.in_b = vb[i]; bus.in_op = vo[i];
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      eb = vo[i] ? ~vb[i] : vb[i];
      checks++;
      if (bus.add_a !== va[i] || bus.add_b !== eb || bus.add_cin !== vo[i]) begin
        errs++;
        $display("FAIL dir%0d_operands: a=%h b=%h cin=%b required a=%h b=%h cin=%b",
                 i, bus.add_a, bus.add_b, bus.add_cin, va[i], eb, vo[i]);
      end
      for (int k = 1; k <= SETTLE; k++) begin
        step();
        checks++;
        if (bus.out_valid !== (k == SETTLE)) begin
          errs++;
          $display("FAIL dir%0d_latency edge %0d: out_valid=%b required %b", i, k, bus.out_valid, k == SETTLE);
        end
      end
      checks++;
      if (bus.out_res !== er[i] || {bus.out_c, bus.out_v, bus.out_z} !== ef[i]) begin
        errs++;
        $display("FAIL dir%0d_result: res=%h cvz=%b%b%b required res=%h cvz=%b",
                 i, bus.out_res, bus.out_c, bus.out_v, bus.out_z, er[i], ef[i]);
      end
      step();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errs++;
        $display("FAIL dir%0d_return_idle: rdy=%b vld=%b required 1/0", i, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        op;
    res_t        e;
    int          n, dly;
    for (int it = 0; it < 40; it++) begin
      a = rnd_operand(); b = rnd_operand(); op = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 3);
      e = model(a, b, op);
      bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      step();
      bus.in_valid = 1'b0;
      bus.in_a = $urandom; bus.in_b = $urandom; bus.in_op = 1'($urandom_range(0, 1));
      n = 0;
      while (!bus.out_valid && n < 20) begin
        step();
        n++;
      end
      checks++;
      if (n != SETTLE) begin
        errs++;
        $display("FAIL rnd%0d_latency: edges=%0d required %0d", it, n, SETTLE);
      end
      repeat (dly) step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.add_a !== a || bus.out_res !== e.res ||
          {bus.out_c, bus.out_v, bus.out_z} !== {e.c, e.v, e.z}) begin
        errs++;
        $display("FAIL rnd%0d_result a=%h b=%h op=%b: vld=%b add_a=%h res=%h cvz=%b%b%b required vld=1 add_a=%h res=%h cvz=%b%b%b",
                 it, a, b, op, bus.out_valid, bus.add_a, bus.out_res, bus.out_c, bus.out_v, bus.out_z,
                 a, e.res, e.c, e.v, e.z);
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_hold();
    res_t e;
    int   n;
    logic bad;
    e = model(32'h1234_5678, 32'h0000_1111, 1'b1);
    bus.in_a = 32'h1234_5678; bus.in_b = 32'h0000_1111; bus.in_op = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!bus.out_valid) begin
      errs++;
      $display("FAIL hold_reach_done: out_valid=0 after %0d edges required 1", n);
    end
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_a = $urandom; bus.in_b = $urandom;
      step();
      bad = (bus.in_ready !== 1'b0) || (bus.out_valid !== 1'b1) || (bus.out_res !== e.res) ||
            (bus.add_a !== 32'h1234_5678);
      checks++;
      if (bad) begin
        errs++;
        $display("FAIL hold_cycle%0d: rdy=%b vld=%b res=%h add_a=%h required rdy=0 vld=1 res=%h add_a=12345678",
                 k, bus.in_ready, bus.out_valid, bus.out_res, bus.add_a, e.res);
      end
    end
    bus.in_a = 32'hCAFE_0001; bus.in_b = 32'h2; bus.in_op = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.add_a !== 32'h1234_5678) begin
      errs++;
      $display("FAIL hold_no_early_accept: rdy=%b add_a=%h required rdy=1 add_a=12345678", bus.in_ready, bus.add_a);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.add_a !== 32'hCAFE_0001 || bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL hold_next_accept: add_a=%h rdy=%b required add_a=cafe0001 rdy=0", bus.add_a, bus.in_ready);
    end
    repeat (SETTLE + 1) step();
  endtask

  task automatic test_reset_mid();
    logic seen;
    bus.in_a = 32'h0000_0FFF; bus.in_b = 32'h0000_0001; bus.in_op = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.add_a !== 32'd0 || bus.add_b !== 32'd0 ||
        bus.add_cin !== 1'b0 || bus.out_res !== 32'd0 || {bus.out_c, bus.out_v, bus.out_z} !== 3'b000) begin
      errs++;
      $display("FAIL midreset_outputs: rdy=%b vld=%b a=%h b=%h res=%h required rdy=1 others 0",
               bus.in_ready, bus.out_valid, bus.add_a, bus.add_b, bus.out_res);
    end
    seen = 1'b0;
    repeat (10) begin
      step();
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errs++;
      $display("FAIL midreset_abandon: stray activity seen=%b required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    res_t e;
    res_t q[$];
    int   last, acc;
    logic took;
    last = -1; acc = 0;
    bus.in_a = rnd_operand(); bus.in_b = rnd_operand(); bus.in_op = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      took = bus.in_ready;
      if (took) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != SETTLE + 2) begin
            errs++;
            $display("FAIL b2b_spacing: %0d cycles required %0d", cyc - last, SETTLE + 2);
          end
        end
        last = cyc;
        acc++;
        q.push_back(model(bus.in_a, bus.in_b, bus.in_op));
      end
      if (bus.out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL b2b_unexpected_result: res=%h required none", bus.out_res);
        end else begin
          e = q.pop_front();
          if (bus.out_res !== e.res || {bus.out_c, bus.out_v, bus.out_z} !== {e.c, e.v, e.z}) begin
            errs++;
            $display("FAIL b2b_result: res=%h cvz=%b%b%b required res=%h cvz=%b%b%b",
                     bus.out_res, bus.out_c, bus.out_v, bus.out_z, e.res, e.c, e.v, e.z);
          end
        end
      end
      step();
      if (took) begin
        bus.in_a = rnd_operand(); bus.in_b = rnd_operand(); bus.in_op = 1'($urandom_range(0, 1));
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (acc < 6) begin
      errs++;
      $display("FAIL b2b_accept_count: %0d required at least 6", acc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
